// File: rtl/rice_core_hazard_controller_pkg.sv
// rice_core_pkg: shared types and defaults for the rice core hazard controller
//   rice_core_hazard_state : decode control FSM states
//   reg_idx_t              : architectural register index
//   RICE_MAX_INFLIGHT      : default outstanding-write limit per register
package rice_core_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} rice_core_hazard_state;
    typedef logic [4:0] reg_idx_t;
    localparam int RICE_MAX_INFLIGHT = 3;
endpackage

// File: rtl/rice_core_hazard_controller_scoreboard.sv
// rice_core_scoreboard: per-register in-flight write counters with busy flag
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_inc_en, i_inc_idx    : count one more outstanding write to a register
//   i_dec_en, i_dec_idx    : one outstanding write to a register completes
//   i_rs1/rs2/rd_idx       : read ports, counters returned on o_rs1/rs2/rd_cnt
//   o_busy                 : registered OR of all counters nonzero
module rice_core_scoreboard
    import rice_core_pkg::*;
#(
    parameter int MAX_INFLIGHT = RICE_MAX_INFLIGHT,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_inc_en,
    input  reg_idx_t      i_inc_idx,
    input  logic          i_dec_en,
    input  reg_idx_t      i_dec_idx,
    input  reg_idx_t      i_rs1_idx,
    input  reg_idx_t      i_rs2_idx,
    input  reg_idx_t      i_rd_idx,
    output logic [CW-1:0] o_rs1_cnt,
    output logic [CW-1:0] o_rs2_cnt,
    output logic [CW-1:0] o_rd_cnt,
    output logic          o_busy
);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic          busy_q, busy_d;
    logic          inc, dec;

    // x0 is never tracked; a simultaneous issue and retire on one register cancels out.
    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        busy_d = 1'b0;
        for (int r = 0; r < 32; r++) begin
            inc = i_inc_en && i_inc_idx == reg_idx_t'(r);
            dec = i_dec_en && i_dec_idx == reg_idx_t'(r);
            cnt_d[r] = (r == 0 || (inc && dec)) ? cnt_q[r]
                     : (inc && cnt_q[r] != CNT_MAX) ? cnt_q[r] + CW'(1)
                     : (dec && cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : cnt_q[r];
            busy_d = busy_d || cnt_q[r] != '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign o_rs1_cnt = cnt_q[i_rs1_idx];
    assign o_rs2_cnt = cnt_q[i_rs2_idx];
    assign o_rd_cnt = cnt_q[i_rd_idx];
    assign o_busy = busy_q;

    // Retiring a register with nothing in flight is a protocol error.
    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_dec_en && i_dec_idx != '0 && cnt_q[i_dec_idx] == '0));
endmodule

// File: rtl/rice_core_hazard_controller.sv
// rice_core_hazard_controller: decode-stage stall/flush/issue control with write scoreboard
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_enable                       : core enable
//   i_issue_valid, i_issue_rs1/rs2/rd : decode instruction requesting issue
//   i_retire_valid, i_retire_rd    : write-back completion
//   i_flush_req                    : redirect from execute
//   o_stall, o_flush               : IF/ID hold and clear
//   o_issue_ack                    : instruction issues this cycle
//   o_busy                         : any register write in flight (registered)
//   Macro RICE_CORE_HAZARD_RETIRE_BYPASS_EN lets a source whose last write retires this
//   cycle issue immediately (execute forwards the write-back value).
module rice_core_hazard_controller
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MAX_INFLIGHT = RICE_MAX_INFLIGHT,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_issue_valid,
    input  logic [4:0] i_issue_rs1,
    input  logic [4:0] i_issue_rs2,
    input  logic [4:0] i_issue_rd,
    input  logic       i_retire_valid,
    input  logic [4:0] i_retire_rd,
    input  logic       i_flush_req,
    output logic       o_stall,
    output logic       o_flush,
    output logic       o_issue_ack,
    output logic       o_busy
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    if (XLEN < 1) begin : g_xlen_chk
        $error("XLEN must be positive");
    end

    rice_core_hazard_state state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic          byp_rs1, byp_rs2, in_run, hazard, inc_en, dec_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            fcnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q <= fcnt_d;
        end
    end

    // A redirect during FLUSH restarts the flush window.
    always_comb begin
        state_d = state_q;
        fcnt_d = fcnt_q;
        case (state_q)
            IDLE: state_d = i_enable ? RUN : IDLE;
            RUN: begin
                state_d = i_flush_req ? FLUSH : (i_enable ? RUN : IDLE);
                fcnt_d = i_flush_req ? FLUSH_LOAD : fcnt_q;
            end
            FLUSH: begin
                state_d = (!i_flush_req && fcnt_q == '0) ? (i_enable ? RUN : IDLE) : FLUSH;
                fcnt_d = i_flush_req ? FLUSH_LOAD : (fcnt_q == '0 ? fcnt_q : fcnt_q - FW'(1));
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef RICE_CORE_HAZARD_RETIRE_BYPASS_EN
        byp_rs1 = i_retire_valid && i_retire_rd == i_issue_rs1 && rs1_cnt == CW'(1);
        byp_rs2 = i_retire_valid && i_retire_rd == i_issue_rs2 && rs2_cnt == CW'(1);
`else
        byp_rs1 = 1'b0;
        byp_rs2 = 1'b0;
`endif
        in_run = state_q == RUN;
        hazard = in_run && i_issue_valid &&
                 ((i_issue_rs1 != '0 && rs1_cnt != '0 && !byp_rs1) ||
                  (i_issue_rs2 != '0 && rs2_cnt != '0 && !byp_rs2) ||
                  (i_issue_rd != '0 && rd_cnt == CNT_MAX));
        o_flush = state_q == FLUSH || (in_run && i_flush_req);
        o_stall = (hazard && !o_flush) || (state_q == IDLE && i_issue_valid);
        o_issue_ack = in_run && i_issue_valid && !hazard && !i_flush_req;
        inc_en = o_issue_ack && i_issue_rd != '0;
        dec_en = i_retire_valid && i_retire_rd != '0;
    end

    rice_core_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_inc_en  (inc_en),
        .i_inc_idx (i_issue_rd),
        .i_dec_en  (dec_en),
        .i_dec_idx (i_retire_rd),
        .i_rs1_idx (i_issue_rs1),
        .i_rs2_idx (i_issue_rs2),
        .i_rd_idx  (i_issue_rd),
        .o_rs1_cnt (rs1_cnt),
        .o_rs2_cnt (rs2_cnt),
        .o_rd_cnt  (rd_cnt),
        .o_busy    (o_busy)
    );
endmodule
